turn_sequencer: RTL and testbench
=================================

# turn_sequencer

Parametrised turn and deal sequencer for the card-game controller, generalising the fixed two-player turn logic to 2–4 players with an initial-deal phase, draw handshake and optional turn timeout. It sits between the game control top level and the memory/interboard blocks. It runs identically on every board, so all boards agree on whose turn it is. It asserts `transmit` when this board owns the current deal or turn.

## Interface
- `NUM_PLAYERS`, default 2: number of players, legal range 2..4.
- `PLAYER`, default 0: this board's player index, 0..NUM_PLAYERS-1.
- `INIT_HAND`, default 14: cards dealt to each player before the first turn.
- `TURN_LIMIT`, default 0: cycles allowed per local turn. 0 disables the timeout.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `interboard_rst` in 1: synchronous, active-high. Returns to IDLE with the same values as reset.
- `start_game` in 1: level. Sampled in IDLE.
- `done_and_next` in 1: one-cycle pulse. Local player ends the turn.
- `draw_and_next` in 1: one-cycle pulse. Local player draws one card, then ends the turn.
- `remote_next` in 1: one-cycle pulse from interboard. The current remote player ended the turn.
- `deal_ack` in 1: one-cycle pulse. The deck draw requested by `deal_req` completed.
- `deal_req` out 1: level. A deck draw is pending.
- `deal_player` out 2: player receiving the pending draw.
- `turn_player` out 2: player whose turn it is.
- `my_turn` out 1: high when in TURN or DRAW_REQ and `turn_player == PLAYER`.
- `transmit` out 1: high when this board drives the current deal or turn.
- `init_done` out 1: high once the deal phase has finished.
- `timeout` out 1: one-cycle pulse when the local turn expires.
- `round_cnt` out 8: completed rounds, saturating at 255.

## Operation
- States: IDLE, DEAL, TURN, DRAW_REQ.
- IDLE:
  - All outputs are 0.
  - `start_game` high moves to DEAL. `deal_idx` = 0 and `deal_player` = 0.
- DEAL:
  - `deal_req` = 1.
  - On `deal_ack`, `deal_idx` increments and `deal_player` advances mod NUM_PLAYERS. The advance uses a wrap compare, not a divider.
  - When `deal_idx` reaches NUM_PLAYERS*INIT_HAND-1 and `deal_ack` arrives, go to TURN. At the same time set `init_done` = 1, `turn_player` = 0 and `round_cnt` = 0.
  - `transmit` = (`deal_player == PLAYER`).
  - `done_and_next`, `draw_and_next` and `remote_next` are ignored in this state.
- TURN, when `my_turn` is high:
  - `done_and_next` advances the turn.
  - `draw_and_next` goes to DRAW_REQ. If both arrive in the same cycle, `done_and_next` wins.
  - `remote_next` is ignored.
- TURN, when `my_turn` is low:
  - `remote_next` advances the turn.
  - Local pulses are ignored.
- DRAW_REQ:
  - `deal_req` = 1 and `deal_player` = PLAYER.
  - `deal_ack` advances the turn and returns to TURN.
  - Other inputs are ignored.
- Advancing the turn:
  - `turn_player` becomes `turn_player`+1, wrapping from NUM_PLAYERS-1 to 0.
  - On that wrap, `round_cnt` increments, saturating at 255.
- Timeout:
  - Applies only when TURN_LIMIT > 0.
  - The timer counts cycles while in TURN with `my_turn` high. It clears on every change of `turn_player` and on leaving TURN.
  - When the timer reaches TURN_LIMIT-1, `timeout` pulses and the state moves to DRAW_REQ, exactly as for `draw_and_next`.
  - A user pulse in the same cycle takes priority and `timeout` does not fire.
- `transmit` in TURN and DRAW_REQ equals `my_turn`.
- Widths:
  - The timer is $clog2(TURN_LIMIT+1) bits, minimum 1.
  - `deal_idx` is 7 bits, which covers 4×14 = 56 ≤ 106 cards.

## Timing
- All outputs are registered.
- Reset values: state IDLE, all outputs 0, and every counter 0.
- Latencies:
  - `start_game` sampled at cycle n → `deal_req` high at n+1.
  - `deal_ack` at cycle n → `deal_player` and `deal_idx` updated at n+1. `deal_req` stays high through the next deal with no gap.
  - Final `deal_ack` at cycle n → `init_done`=1, `deal_req`=0 and TURN at n+1.
  - `done_and_next` or `remote_next` at cycle n → new `turn_player` and `my_turn` at n+1.
- `deal_ack` is honoured only while `deal_req` is high. Otherwise it is ignored.
- `rst` low at any time clears everything immediately, including mid-deal and mid-DRAW_REQ.
- `interboard_rst` has the same effect at the next edge and takes priority over all other inputs.

## Test plan
- NUM_PLAYERS=2, PLAYER=1, INIT_HAND=14:
  - Stimulus: `start_game`, then 28 `deal_ack` pulses.
  - Required: `deal_player` alternates 0,1,…; `transmit` is high on odd deals only; after the 28th ack, `init_done`=1, `turn_player`=0 and `my_turn`=0.
- NUM_PLAYERS=3, PLAYER=0, after the deal:
  - Stimulus: `done_and_next`, then `remote_next`, then `remote_next`.
  - Required: `turn_player` 0→1→2→0; `round_cnt`=1.
  - Stimulus: a `done_and_next` pulse while `turn_player`=1.
  - Required: no change.
- Draw path:
  - Stimulus: on my turn, pulse `draw_and_next`, then hold `deal_ack` off for 5 cycles.
  - Required: `deal_req`=1 and `deal_player`=PLAYER throughout; the ack then advances `turn_player` one cycle later.
  - Stimulus: `done_and_next` and `draw_and_next` in the same cycle.
  - Required: the turn advances with no draw.
- TURN_LIMIT=10:
  - Stimulus: idle on my turn.
  - Required: `timeout` pulses exactly 10 cycles after turn entry; DRAW_REQ follows.
  - Stimulus: `done_and_next` at cycle 9.
  - Required: no timeout.
- Reset mid-operation:
  - Stimulus: `rst` low mid-deal (deal_idx=7).
  - Required: all outputs 0 asynchronously.
  - Stimulus: `interboard_rst` during TURN.
  - Required: IDLE and `round_cnt`=0 next cycle; `start_game` restarts the deal from `deal_idx` 0.
- `round_cnt` saturation:
  - Stimulus: 600 turn advances with NUM_PLAYERS=2.
  - Required: `round_cnt` holds at 255.

Source files
------------

// File: rtl/turn_sequencer.sv
// turn_sequencer: deal and turn sequencer for the multi-board card game.
// Every board runs an identical copy, so the deal order, the current turn and
// the round count stay in lock-step across boards. This board drives the bus
// (transmit) whenever it owns the current deal or the current turn.
module turn_sequencer #(
    parameter int NUM_PLAYERS = 2,   // 2..4
    parameter int PLAYER      = 0,   // this board, 0..NUM_PLAYERS-1
    parameter int INIT_HAND   = 14,  // cards dealt to each player up front
    parameter int TURN_LIMIT  = 0    // cycles per local turn, 0 = no timeout
) (
    input  logic       clk,
    input  logic       rst,             // asynchronous, active-low
    input  logic       interboard_rst,  // synchronous, active-high
    input  logic       start_game,
    input  logic       done_and_next,
    input  logic       draw_and_next,
    input  logic       remote_next,
    input  logic       deal_ack,
    output logic       deal_req,
    output logic [1:0] deal_player,
    output logic [1:0] turn_player,
    output logic       my_turn,
    output logic       transmit,
    output logic       init_done,
    output logic       timeout,
    output logic [7:0] round_cnt
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEAL     = 2'd1;
    localparam logic [1:0] ST_TURN     = 2'd2;
    localparam logic [1:0] ST_DRAW_REQ = 2'd3;

    localparam logic [1:0] LOCAL_PLAYER = 2'(PLAYER);
    localparam logic [1:0] LAST_PLAYER  = 2'(NUM_PLAYERS - 1);

    // Index of the final card of the initial deal.
    localparam logic [6:0] DEAL_LAST = 7'(NUM_PLAYERS * INIT_HAND - 1);

    // The turn timer keeps one bit even when the timeout is disabled, so the
    // declarations stay legal; it then simply never leaves zero.
    localparam bit TIMER_EN = (TURN_LIMIT > 0);
    localparam int TIMER_W  = TIMER_EN ? $clog2(TURN_LIMIT + 1) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMER_EN ? TURN_LIMIT - 1 : 0);

    // ------------------------------------------------------------------
    // State and next-state signals
    // ------------------------------------------------------------------
    logic [1:0]         state, state_nxt;
    logic [6:0]         deal_idx, deal_idx_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;

    logic       deal_req_nxt;
    logic [1:0] deal_player_nxt;
    logic [1:0] turn_player_nxt;
    logic       my_turn_nxt;
    logic       transmit_nxt;
    logic       init_done_nxt;
    logic       timeout_nxt;
    logic [7:0] round_cnt_nxt;

    logic ack_ok;        // a deck draw completed while one was pending
    logic turn_advance;  // hand the turn to the next player this cycle
    logic turn_wrap;     // the advance wraps back to player 0

    assign ack_ok    = deal_ack & deal_req;
    assign turn_wrap = (turn_player == LAST_PLAYER);

    // Next-state logic for the FSM, the deal counter and the turn timer.
    always_comb begin
        // NOTE: every variable written here gets a default first so that no
        // path leaves one unassigned and no latch is inferred.
        state_nxt       = state;
        deal_idx_nxt    = deal_idx;
        timer_nxt       = '0;
        deal_player_nxt = '0;
        init_done_nxt   = init_done;
        timeout_nxt     = 1'b0;
        turn_advance    = 1'b0;
        turn_player_nxt = turn_player;
        round_cnt_nxt   = round_cnt;

        case (state)
            ST_IDLE: begin
                if (start_game) begin
                    state_nxt    = ST_DEAL;
                    deal_idx_nxt = '0;
                end
            end

            ST_DEAL: begin
                // Turn pulses are meaningless before the deal has finished.
                deal_player_nxt = deal_player;
                if (ack_ok) begin
                    if (deal_idx == DEAL_LAST) begin
                        state_nxt       = ST_TURN;
                        deal_idx_nxt    = '0;
                        deal_player_nxt = '0;
                        init_done_nxt   = 1'b1;
                        turn_player_nxt = '0;
                        round_cnt_nxt   = '0;
                    end else begin
                        deal_idx_nxt    = deal_idx + 7'd1;
                        // Round-robin by wrap compare rather than a modulo.
                        deal_player_nxt = (deal_player == LAST_PLAYER) ? 2'd0
                                                                       : deal_player + 2'd1;
                    end
                end
            end

            ST_TURN: begin
                if (my_turn) begin
                    // User pulses outrank the timer, and ending the turn
                    // outranks drawing when both arrive together.
                    if (done_and_next) begin
                        turn_advance = 1'b1;
                    end else if (draw_and_next) begin
                        state_nxt = ST_DRAW_REQ;
                    end else if (TIMER_EN && (timer == TIMER_LAST)) begin
                        timeout_nxt = 1'b1;
                        state_nxt   = ST_DRAW_REQ;
                    end else if (TIMER_EN) begin
                        timer_nxt = timer + 1'b1;
                    end
                end else if (remote_next) begin
                    turn_advance = 1'b1;
                end
            end

            ST_DRAW_REQ: begin
                // The local player waits for the deck; everything else waits.
                if (ack_ok) begin
                    turn_advance = 1'b1;
                    state_nxt    = ST_TURN;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (turn_advance) begin
            turn_player_nxt = turn_wrap ? 2'd0 : turn_player + 2'd1;
            if (turn_wrap && (round_cnt != 8'hFF)) begin
                round_cnt_nxt = round_cnt + 8'd1;
            end
        end

        // A draw for the local player is the only pending draw outside DEAL.
        if (state_nxt == ST_DRAW_REQ) begin
            deal_player_nxt = LOCAL_PLAYER;
        end
    end

    // Output decode from the next state, so every output comes from a flop.
    always_comb begin
        deal_req_nxt = (state_nxt == ST_DEAL) || (state_nxt == ST_DRAW_REQ);
        my_turn_nxt  = ((state_nxt == ST_TURN) || (state_nxt == ST_DRAW_REQ)) &&
                       (turn_player_nxt == LOCAL_PLAYER);
        transmit_nxt = (state_nxt == ST_DEAL) ? (deal_player_nxt == LOCAL_PLAYER)
                                              : my_turn_nxt;
    end

    // State and output registers; both resets return to IDLE with all zeros.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            deal_idx    <= '0;
            timer       <= '0;
            deal_req    <= 1'b0;
            deal_player <= '0;
            turn_player <= '0;
            my_turn     <= 1'b0;
            transmit    <= 1'b0;
            init_done   <= 1'b0;
            timeout     <= 1'b0;
            round_cnt   <= '0;
        end else if (interboard_rst) begin
            state       <= ST_IDLE;
            deal_idx    <= '0;
            timer       <= '0;
            deal_req    <= 1'b0;
            deal_player <= '0;
            turn_player <= '0;
            my_turn     <= 1'b0;
            transmit    <= 1'b0;
            init_done   <= 1'b0;
            timeout     <= 1'b0;
            round_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values and the update order does not matter.
            state       <= state_nxt;
            deal_idx    <= deal_idx_nxt;
            timer       <= timer_nxt;
            deal_req    <= deal_req_nxt;
            deal_player <= deal_player_nxt;
            turn_player <= turn_player_nxt;
            my_turn     <= my_turn_nxt;
            transmit    <= transmit_nxt;
            init_done   <= init_done_nxt;
            timeout     <= timeout_nxt;
            round_cnt   <= round_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_turn_sequencer.sv
// Testbench for turn_sequencer. Two instances run side by side:
//   dut_a: 2 players, this board = 1, 14 cards each, no timeout
//   dut_b: 3 players, this board = 0, 2 cards each, 10-cycle turn limit
// Every cycle both are compared with a behavioural game model; a fixed
// vector table and hand-written sequences add constant expectations.
module tb_turn_sequencer;

    localparam int A_N = 2, A_P = 1, A_H = 14, A_TL = 0;
    localparam int B_N = 3, B_P = 0, B_H = 2,  B_TL = 10;

    typedef struct packed {
        bit ib;
        bit start;
        bit done;
        bit draw;
        bit remote;
        bit ack;
    } in_t;

    typedef struct packed {
        logic       deal_req;
        logic [1:0] deal_player;
        logic [1:0] turn_player;
        logic       my_turn;
        logic       transmit;
        logic       init_done;
        logic       timeout;
        logic [7:0] round_cnt;
    } out_t;

    typedef enum int {PH_IDLE, PH_DEAL, PH_TURN, PH_DRAW} phase_e;

    typedef struct {
        phase_e phase;
        int     deals;   // cards dealt so far
        int     turn;
        int     rounds;  // unbounded; saturated when turned into an output
        int     age;     // cycles spent so far in the current local turn
        bit     init;
        bit     timeout;
    } mdl_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } vec_t;

    localparam in_t I_NONE   = 6'b000000;
    localparam in_t I_IB     = 6'b100000;
    localparam in_t I_START  = 6'b010000;
    localparam in_t I_DONE   = 6'b001000;
    localparam in_t I_DRAW   = 6'b000100;
    localparam in_t I_REMOTE = 6'b000010;
    localparam in_t I_ACK    = 6'b000001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    in_t  in_a, in_b;
    out_t act_a, act_b;
    mdl_t m_a, m_b;
    int   vectors = 0;
    int   miscompares = 0;

    logic       a_deal_req, a_my_turn, a_transmit, a_init_done, a_timeout;
    logic [1:0] a_deal_player, a_turn_player;
    logic [7:0] a_round_cnt;
    logic       b_deal_req, b_my_turn, b_transmit, b_init_done, b_timeout;
    logic [1:0] b_deal_player, b_turn_player;
    logic [7:0] b_round_cnt;

    always #5 clk = ~clk;

    turn_sequencer #(.NUM_PLAYERS(A_N), .PLAYER(A_P), .INIT_HAND(A_H), .TURN_LIMIT(A_TL)) dut_a (
        .clk(clk), .rst(rst), .interboard_rst(in_a.ib), .start_game(in_a.start),
        .done_and_next(in_a.done), .draw_and_next(in_a.draw), .remote_next(in_a.remote),
        .deal_ack(in_a.ack), .deal_req(a_deal_req), .deal_player(a_deal_player),
        .turn_player(a_turn_player), .my_turn(a_my_turn), .transmit(a_transmit),
        .init_done(a_init_done), .timeout(a_timeout), .round_cnt(a_round_cnt)
    );

    turn_sequencer #(.NUM_PLAYERS(B_N), .PLAYER(B_P), .INIT_HAND(B_H), .TURN_LIMIT(B_TL)) dut_b (
        .clk(clk), .rst(rst), .interboard_rst(in_b.ib), .start_game(in_b.start),
        .done_and_next(in_b.done), .draw_and_next(in_b.draw), .remote_next(in_b.remote),
        .deal_ack(in_b.ack), .deal_req(b_deal_req), .deal_player(b_deal_player),
        .turn_player(b_turn_player), .my_turn(b_my_turn), .transmit(b_transmit),
        .init_done(b_init_done), .timeout(b_timeout), .round_cnt(b_round_cnt)
    );

    assign act_a = {a_deal_req, a_deal_player, a_turn_player, a_my_turn, a_transmit,
                    a_init_done, a_timeout, a_round_cnt};
    assign act_b = {b_deal_req, b_deal_player, b_turn_player, b_my_turn, b_transmit,
                    b_init_done, b_timeout, b_round_cnt};

    // ---------------- reference model ----------------
    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.phase = PH_IDLE; r.deals = 0; r.turn = 0; r.rounds = 0;
        r.age = 0; r.init = 1'b0; r.timeout = 1'b0;
        return r;
    endfunction

    function automatic mdl_t mdl_advance(mdl_t r, int n);
        r.turn = (r.turn + 1) % n;
        if (r.turn == 0) r.rounds = r.rounds + 1;
        return r;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, in_t i, int n, int p, int h, int tl);
        mdl_t r = m;
        r.timeout = 1'b0;
        if (i.ib) return mdl_reset();
        case (m.phase)
            PH_IDLE: if (i.start) begin r.phase = PH_DEAL; r.deals = 0; end
            PH_DEAL: if (i.ack) begin
                r.deals = m.deals + 1;
                if (r.deals == n * h) begin
                    r.phase = PH_TURN; r.init = 1'b1; r.turn = 0; r.rounds = 0;
                end
            end
            PH_TURN: begin
                if (m.turn == p) begin
                    if (i.done)                             r = mdl_advance(r, n);
                    else if (i.draw)                        r.phase = PH_DRAW;
                    else if (tl > 0 && m.age == tl - 1)     begin r.timeout = 1'b1; r.phase = PH_DRAW; end
                    else                                    r.age = m.age + 1;
                end else if (i.remote) begin
                    r = mdl_advance(r, n);
                end
            end
            PH_DRAW: if (i.ack) begin r = mdl_advance(r, n); r.phase = PH_TURN; end
            default: r = mdl_reset();
        endcase
        if (r.phase != PH_TURN || r.turn != m.turn) r.age = 0;
        return r;
    endfunction

    function automatic out_t exp_out(mdl_t m, int n, int p);
        out_t o = '0;
        o.deal_req    = (m.phase == PH_DEAL) || (m.phase == PH_DRAW);
        o.deal_player = (m.phase == PH_DEAL) ? 2'(m.deals % n) :
                        (m.phase == PH_DRAW) ? 2'(p) : 2'd0;
        o.turn_player = 2'(m.turn);
        o.my_turn     = ((m.phase == PH_TURN) || (m.phase == PH_DRAW)) && (m.turn == p);
        o.transmit    = (m.phase == PH_DEAL) ? ((m.deals % n) == p) : o.my_turn;
        o.init_done   = m.init;
        o.timeout     = m.timeout;
        o.round_cnt   = (m.rounds > 255) ? 8'd255 : 8'(m.rounds);
        return o;
    endfunction

    // No draw is pending during a turn, so the deal player is not compared there.
    function automatic out_t mask(out_t o, phase_e ph);
        if (ph == PH_TURN) o.deal_player = '0;
        return o;
    endfunction

    function automatic out_t mk_out(bit dr, int dp, int tp, bit mt, bit tx, bit id, bit to, int rc);
        out_t o;
        o.deal_req = dr; o.deal_player = 2'(dp); o.turn_player = 2'(tp); o.my_turn = mt;
        o.transmit = tx; o.init_done = id; o.timeout = to; o.round_cnt = 8'(rc);
        return o;
    endfunction

    function automatic in_t rand_in();
        in_t r;
        r.ib     = ($urandom_range(0, 99) == 0);
        r.start  = ($urandom_range(0, 3) == 0);
        r.done   = ($urandom_range(0, 4) == 0);
        r.draw   = ($urandom_range(0, 6) == 0);
        r.remote = ($urandom_range(0, 2) == 0);
        r.ack    = ($urandom_range(0, 4) < 2);
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_models();
        check("a_vs_model", 32'(mask(act_a, m_a.phase)), 32'(mask(exp_out(m_a, A_N, A_P), m_a.phase)));
        check("b_vs_model", 32'(mask(act_b, m_b.phase)), 32'(mask(exp_out(m_b, B_N, B_P), m_b.phase)));
    endtask

    // One clock: drive at the falling edge, step models at the rising edge,
    // compare at the next falling edge.
    task automatic cycle(in_t a, in_t b);
        in_a = a;
        in_b = b;
        @(posedge clk);
        m_a = mdl_step(m_a, a, A_N, A_P, A_H, A_TL);
        m_b = mdl_step(m_b, b, B_N, B_P, B_H, B_TL);
        @(negedge clk);
        compare_models();
        in_a = I_NONE;
        in_b = I_NONE;
    endtask

    task automatic pa(in_t a);
        cycle(a, I_NONE);
    endtask

    task automatic pb(in_t b);
        cycle(I_NONE, b);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   seen;

        tbl[0] = '{I_NONE,  mk_out(0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[1] = '{I_START, mk_out(1, 0, 0, 0, 0, 0, 0, 0)};
        tbl[2] = '{I_ACK,   mk_out(1, 1, 0, 0, 1, 0, 0, 0)};
        tbl[3] = '{I_NONE,  mk_out(1, 1, 0, 0, 1, 0, 0, 0)};
        tbl[4] = '{I_ACK,   mk_out(1, 0, 0, 0, 0, 0, 0, 0)};
        tbl[5] = '{I_ACK,   mk_out(1, 1, 0, 0, 1, 0, 0, 0)};

        in_a = I_NONE;
        in_b = I_NONE;
        m_a  = mdl_reset();
        m_b  = mdl_reset();
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_a", 32'(act_a), 32'd0);
        check("reset_b", 32'(act_b), 32'd0);
        rst = 1'b1;

        // Opening of the 2-player deal from a fixed table.
        for (int i = 0; i < 6; i++) begin
            pa(tbl[i].in);
            check($sformatf("table_%0d", i), 32'(act_a), 32'(tbl[i].exp));
        end

        // Remaining 25 deals with random gaps between acks.
        for (int k = 3; k < A_N * A_H; k++) begin
            repeat ($urandom_range(0, 2)) pa(I_NONE);
            pa(I_ACK);
        end
        check("a_init_done", 32'(a_init_done), 32'd1);
        check("a_turn_after_deal", 32'(a_turn_player), 32'd0);
        check("a_my_turn_after_deal", 32'(a_my_turn), 32'd0);
        check("a_deal_req_after_deal", 32'(a_deal_req), 32'd0);

        // 3-player board: deal, then rotate through everyone.
        pb(I_START);
        repeat (B_N * B_H) pb(I_ACK);
        check("b_init_done", 32'(b_init_done), 32'd1);
        check("b_my_turn_start", 32'(b_my_turn), 32'd1);
        pb(I_DONE);
        check("b_turn_1", 32'(b_turn_player), 32'd1);
        pb(I_REMOTE);
        check("b_turn_2", 32'(b_turn_player), 32'd2);
        pb(I_REMOTE);
        check("b_turn_0", 32'(b_turn_player), 32'd0);
        check("b_round_1", 32'(b_round_cnt), 32'd1);

        // Idle on the local turn until the timer expires.
        seen = -1;
        for (int k = 1; k <= 20 && seen < 0; k++) begin
            pb(I_NONE);
            if (b_timeout === 1'b1) seen = k;
        end
        check("b_timeout_latency", 32'(seen), 32'd10);
        check("b_timeout_draw_req", 32'(b_deal_req), 32'd1);
        repeat (5) begin
            pb(I_NONE);
            check("b_draw_hold_req", 32'(b_deal_req), 32'd1);
            check("b_draw_hold_player", 32'(b_deal_player), 32'(B_P));
        end
        pb(I_ACK);
        check("b_draw_ack_turn", 32'(b_turn_player), 32'd1);

        // A local pulse on a remote turn changes nothing.
        pb(I_DONE);
        check("b_done_not_mine", 32'(b_turn_player), 32'd1);
        pb(I_REMOTE);
        pb(I_REMOTE);
        check("b_round_2", 32'(b_round_cnt), 32'd2);

        // Ending the turn at cycle 9 beats the timer.
        repeat (9) pb(I_NONE);
        pb(I_DONE);
        check("b_done_c9_timeout", 32'(b_timeout), 32'd0);
        check("b_done_c9_turn", 32'(b_turn_player), 32'd1);
        pb(I_REMOTE);
        pb(I_REMOTE);

        // Draw path with a slow deck.
        pb(I_DRAW);
        check("b_draw_req", 32'(b_deal_req), 32'd1);
        repeat (5) begin
            pb(I_NONE);
            check("b_draw_wait_req", 32'(b_deal_req), 32'd1);
            check("b_draw_wait_player", 32'(b_deal_player), 32'(B_P));
            check("b_draw_wait_turn", 32'(b_turn_player), 32'd0);
        end
        pb(I_ACK);
        check("b_draw_done_turn", 32'(b_turn_player), 32'd1);
        check("b_draw_done_req", 32'(b_deal_req), 32'd0);
        pb(I_REMOTE);
        pb(I_REMOTE);

        // Done and draw together: done wins, no draw.
        pb(in_t'(I_DONE | I_DRAW));
        check("b_both_turn", 32'(b_turn_player), 32'd1);
        check("b_both_req", 32'(b_deal_req), 32'd0);

        // Random traffic on both boards against the model.
        repeat (400) cycle(rand_in(), rand_in());

        // Saturation of the round counter.
        pa(I_IB);
        check("a_ib_idle", 32'(act_a), 32'd0);
        pa(I_START);
        repeat (A_N * A_H) pa(I_ACK);
        for (int k = 0; k < 600; k++) begin
            if (m_a.turn == A_P) pa(I_DONE);
            else                 pa(I_REMOTE);
        end
        check("a_round_sat", 32'(a_round_cnt), 32'd255);

        // Interboard reset during a turn, then a fresh deal.
        pa(I_IB);
        check("a_ib_turn_outputs", 32'(act_a), 32'd0);
        pa(I_START);
        check("a_restart_req", 32'(a_deal_req), 32'd1);
        check("a_restart_player", 32'(a_deal_player), 32'd0);
        repeat (7) pa(I_ACK);

        // Asynchronous reset in the middle of the deal.
        #2 rst = 1'b0;
        #1;
        check("a_async_rst", 32'(act_a), 32'd0);
        check("b_async_rst", 32'(act_b), 32'd0);
        m_a = mdl_reset();
        m_b = mdl_reset();
        @(negedge clk);
        rst = 1'b1;
        pa(I_START);
        pa(I_ACK);
        check("a_after_rst_player", 32'(a_deal_player), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
